// File: rtl/sd_emmc_ddr_data_rx.sv
// eMMC DDR52 receive data path. Finds the start bit in paired rising/falling
// DAT samples, deserialises one block on a 4- or 8-bit bus, checks the
// per-line per-edge CRC16 and the end bit, and reports status to the host side.
module sd_emmc_ddr_data_rx #(
    parameter int TIMEOUT_W = 24,
    parameter int BLEN_W    = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 bus8,
    input  logic [BLEN_W-1:0]    block_bytes,
    input  logic [TIMEOUT_W-1:0] timeout,
    input  logic [7:0]           d_rise,
    input  logic [7:0]           d_fall,
    output logic                 rx_valid,
    output logic [15:0]          rx_data,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_err,
    output logic                 end_err,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC        = 3'd3,
        ST_END        = 3'd4
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TMO_ONE    = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] TMO_ZERO   = TIMEOUT_W'(0);
    localparam logic [BLEN_W-1:0]    BLEN_ONE   = BLEN_W'(1);
    localparam logic [BLEN_W-1:0]    BLEN_ZERO  = BLEN_W'(0);
    localparam logic [15:0]          CRC16_POLY = 16'h1021;

    // One serial CRC16 step (x^16+x^12+x^5+1, MSB first).
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

    // Drain step used while comparing: the MSB has been checked, shift in 0.
    function automatic logic [15:0] crc16_drain(input logic [15:0] crc);
        crc16_drain = {crc[14:0], 1'b0};
    endfunction

    state_t                 state_r;
    state_t                 state_n;
    logic                   bus8_r;
    logic [BLEN_W-1:0]      last_cnt_r;
    logic [BLEN_W-1:0]      cnt_r;
    logic [TIMEOUT_W-1:0]   tmo_r;
    logic [TIMEOUT_W-1:0]   tcnt_r;
    logic [3:0]             crc_cnt_r;
    logic [3:0]             nib_rise_r;
    logic [3:0]             nib_fall_r;
    // Engines 0..7 follow the rising-edge bit of lines 0..7, 8..15 the falling edge.
    logic [15:0]            crc_r [16];

    logic [7:0]             line_mask_s;
    logic [BLEN_W-1:0]      len_even_s;
    logic [BLEN_W-1:0]      last_cnt_s;
    logic                   start_ok_s;
    logic                   start_bit_s;
    logic                   end_ok_s;
    logic                   tmo_hit_s;
    logic                   data_last_s;
    logic                   crc_last_s;
    logic [7:0]             msb_rise_s;
    logic [7:0]             msb_fall_s;
    logic                   crc_mis_s;

    // Decode helpers: active-line mask, start/end bit, counters, CRC compare.
    always_comb begin
        line_mask_s = 8'h0F;
        last_cnt_s  = BLEN_ZERO;
        start_ok_s  = 1'b0;
        msb_rise_s  = 8'h00;
        msb_fall_s  = 8'h00;
        if (bus8_r) begin
            line_mask_s = 8'hFF;
        end else begin
            line_mask_s = 8'h0F;
        end
        // Length is forced even; bit 0 of the request never matters.
        len_even_s = block_bytes & ~BLEN_ONE;
        if (bus8) begin
            last_cnt_s = (len_even_s >> 1) - BLEN_ONE;
        end else begin
            last_cnt_s = len_even_s - BLEN_ONE;
        end
        if ((state_r == ST_IDLE) && start && !abort && (len_even_s != BLEN_ZERO)) begin
            start_ok_s = 1'b1;
        end else begin
            start_ok_s = 1'b0;
        end
        start_bit_s = (((d_rise | d_fall) & line_mask_s) == 8'h00);
        end_ok_s    = (((d_rise & d_fall) | ~line_mask_s) == 8'hFF);
        tmo_hit_s   = (tmo_r != TMO_ZERO) && (tcnt_r == (tmo_r - TMO_ONE));
        data_last_s = (cnt_r == last_cnt_r);
        crc_last_s  = (crc_cnt_r == 4'd15);
        for (int i = 0; i < 8; i++) begin
            msb_rise_s[i] = crc_r[i][15];
            msb_fall_s[i] = crc_r[8 + i][15];
        end
        crc_mis_s = |(((d_rise ^ msb_rise_s) | (d_fall ^ msb_fall_s)) & line_mask_s);
    end

    // Next-state logic; abort always returns to IDLE and beats start.
    always_comb begin
        state_n = state_r;
        if (abort) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) state_n = ST_WAIT_START;
                    else            state_n = ST_IDLE;
                end
                ST_WAIT_START: begin
                    if (start_bit_s)    state_n = ST_DATA;
                    else if (tmo_hit_s) state_n = ST_IDLE;
                    else                state_n = ST_WAIT_START;
                end
                ST_DATA: begin
                    if (data_last_s) state_n = ST_CRC;
                    else             state_n = ST_DATA;
                end
                ST_CRC: begin
                    if (crc_last_s) state_n = ST_END;
                    else            state_n = ST_CRC;
                end
                ST_END:  state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath: configuration capture, counters, deserialiser, registered status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus8_r      <= 1'b0;
            last_cnt_r  <= BLEN_ZERO;
            cnt_r       <= BLEN_ZERO;
            tmo_r       <= TMO_ZERO;
            tcnt_r      <= TMO_ZERO;
            crc_cnt_r   <= 4'd0;
            nib_rise_r  <= 4'd0;
            nib_fall_r  <= 4'd0;
            rx_valid    <= 1'b0;
            rx_data     <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            crc_err     <= 1'b0;
            end_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_ok_s) begin
                            bus8_r      <= bus8;
                            last_cnt_r  <= last_cnt_s;
                            tmo_r       <= timeout;
                            tcnt_r      <= TMO_ZERO;
                            cnt_r       <= BLEN_ZERO;
                            crc_cnt_r   <= 4'd0;
                            busy        <= 1'b1;
                            crc_err     <= 1'b0;
                            end_err     <= 1'b0;
                            timeout_err <= 1'b0;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (start_bit_s) begin
                            tcnt_r <= tcnt_r;
                        end else if (tmo_hit_s) begin
                            timeout_err <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            tcnt_r <= tcnt_r + TMO_ONE;
                        end
                    end
                    ST_DATA: begin
                        cnt_r <= cnt_r + BLEN_ONE;
                        if (bus8_r) begin
                            rx_valid <= 1'b1;
                            rx_data  <= {d_fall, d_rise};
                        end else if (!cnt_r[0]) begin
                            // Even cycle carries the high nibbles; hold them.
                            nib_rise_r <= d_rise[3:0];
                            nib_fall_r <= d_fall[3:0];
                        end else begin
                            rx_valid <= 1'b1;
                            rx_data  <= {nib_fall_r, d_fall[3:0], nib_rise_r, d_rise[3:0]};
                        end
                    end
                    ST_CRC: begin
                        crc_cnt_r <= crc_cnt_r + 4'd1;
                        if (crc_mis_s) begin
                            crc_err <= 1'b1;
                        end else begin
                            crc_err <= crc_err;
                        end
                    end
                    ST_END: begin
                        end_err <= !end_ok_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end
                    default: begin
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

    // CRC engines: cleared on an accepted start, fed in DATA, drained in CRC.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < 16; e++) begin
                crc_r[e] <= 16'h0000;
            end
        end else if (abort) begin
            for (int e = 0; e < 16; e++) begin
                crc_r[e] <= crc_r[e];
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        for (int e = 0; e < 16; e++) begin
                            crc_r[e] <= 16'h0000;
                        end
                    end
                end
                ST_DATA: begin
                    for (int i = 0; i < 8; i++) begin
                        if (line_mask_s[i]) begin
                            crc_r[i]     <= crc16_step(crc_r[i], d_rise[i]);
                            crc_r[8 + i] <= crc16_step(crc_r[8 + i], d_fall[i]);
                        end
                    end
                end
                ST_CRC: begin
                    for (int e = 0; e < 16; e++) begin
                        crc_r[e] <= crc16_drain(crc_r[e]);
                    end
                end
                default: begin
                    for (int e = 0; e < 16; e++) begin
                        crc_r[e] <= crc_r[e];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_emmc_ddr_data_rx.sv
// Directed + randomized bench for sd_emmc_ddr_data_rx. Expected words come
// from the byte array; expected CRCs from GF(2) polynomial long division.
module tb_sd_emmc_ddr_data_rx;
    localparam int TW = 24;
    localparam int BW = 12;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          bus8 = 1'b0;
    logic [BW-1:0] block_bytes = '0;
    logic [TW-1:0] timeout = '0;
    logic [7:0]    d_rise = 8'hFF;
    logic [7:0]    d_fall = 8'hFF;
    logic          rx_valid;
    logic [15:0]   rx_data;
    logic          busy;
    logic          done;
    logic          crc_err;
    logic          end_err;
    logic          timeout_err;

    sd_emmc_ddr_data_rx #(.TIMEOUT_W(TW), .BLEN_W(BW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .bus8(bus8),
        .block_bytes(block_bytes), .timeout(timeout), .d_rise(d_rise), .d_fall(d_fall),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy), .done(done),
        .crc_err(crc_err), .end_err(end_err), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_total = 0;
    int          done_cyc = 0;
    logic [15:0] words[$];
    int          vcyc[$];
    logic [7:0]  blk [0:4095];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (rx_valid) begin
            words.push_back(rx_data);
            vcyc.push_back(cyc);
        end
        if (done) begin
            done_total <= done_total + 1;
            done_cyc   <= cyc;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC16 as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_div(input bit msg[$]);
        bit          w[$];
        logic [16:0] g;
        logic [15:0] rem;
        g = 17'h11021;
        w = msg;
        for (int i = 0; i < 16; i++) w.push_back(1'b0);
        for (int i = 0; i + 16 < w.size(); i++)
            if (w[i]) for (int j = 0; j < 17; j++) w[i + j] = w[i + j] ^ g[16 - j];
        for (int j = 0; j < 16; j++) rem[15 - j] = w[w.size() - 16 + j];
        return rem;
    endfunction

    task automatic wait_done(input int dbase, input int budget, input string tag);
        int t;
        t = 0;
        while (done_total == dbase && t < budget) begin
            @(negedge clock); #1;
            t++;
        end
        repeat (3) begin @(negedge clock); #1; end
        check({tag, "_done_count"}, done_total - dbase, 1);
    endtask

    task automatic send_block(input bit b8, input int nbytes, input int tmo, input int gap,
                              input int flip_eng, input bit bad_end, input int stop_word,
                              input bit use_reset);
        int          nb, ncyc, dbase, wbase, sb_cyc;
        logic [7:0]  mask, r, f, be, bo;
        logic [7:0]  rs[$];
        logic [7:0]  fs[$];
        logic [15:0] crc_e [16];
        bit          q[$];
        bit          exp_crc;
        nb    = nbytes & ~1;
        ncyc  = b8 ? nb / 2 : nb;
        mask  = b8 ? 8'hFF : 8'h0F;
        dbase = done_total;
        wbase = words.size();
        for (int k = 0; k < ncyc; k++) begin
            if (b8) begin
                r = blk[2 * k];
                f = blk[2 * k + 1];
            end else begin
                be = blk[2 * (k / 2)];
                bo = blk[2 * (k / 2) + 1];
                r = {4'($urandom), (k % 2 == 0) ? be[7:4] : be[3:0]};
                f = {4'($urandom), (k % 2 == 0) ? bo[7:4] : bo[3:0]};
            end
            rs.push_back(r);
            fs.push_back(f);
        end
        for (int e = 0; e < 16; e++) begin
            q.delete();
            for (int k = 0; k < ncyc; k++) q.push_back(e < 8 ? rs[k][e % 8] : fs[k][e % 8]);
            crc_e[e] = crc_div(q);
        end
        @(negedge clock);
        start = 1'b1; bus8 = b8; block_bytes = BW'(nbytes); timeout = TW'(tmo);
        @(negedge clock);
        start = 1'b0; bus8 = 1'($urandom); block_bytes = BW'($urandom); timeout = TW'($urandom);
        #1;
        check("blk_busy_on", busy, 1);
        check("blk_flags_clear", {crc_err, end_err, timeout_err}, 0);
        repeat (gap) begin @(negedge clock); d_rise = 8'hFF; d_fall = 8'hFF; end
        @(negedge clock);
        d_rise = 8'($urandom) & ~mask;
        d_fall = 8'($urandom) & ~mask;
        sb_cyc = cyc;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clock);
            d_rise = rs[k];
            d_fall = fs[k];
            if (k == stop_word) begin
                if (use_reset) begin
                    #2 reset = 1'b0;
                    #1 check("rst_busy_async", busy, 0);
                end else begin
                    abort = 1'b1;
                end
                @(negedge clock);
                abort = 1'b0; reset = 1'b1; d_rise = 8'hFF; d_fall = 8'hFF;
                #1;
                check("stop_busy", busy, 0);
                check("stop_valid", rx_valid, 0);
                repeat (40) @(negedge clock);
                #1;
                check("stop_no_done", done_total - dbase, 0);
                check("stop_words", words.size() - wbase, stop_word);
                check("stop_last_word", words[words.size() - 1],
                      {blk[2 * stop_word - 1], blk[2 * stop_word - 2]});
                check("stop_flags", {crc_err, end_err, timeout_err}, 0);
                return;
            end
        end
        for (int j = 0; j < 16; j++) begin
            @(negedge clock);
            r = 8'($urandom);
            f = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                r[i] = crc_e[i][15 - j];
                f[i] = crc_e[8 + i][15 - j];
            end
            if (flip_eng >= 0 && j == 7) begin
                if (flip_eng < 8) r[flip_eng] = ~r[flip_eng];
                else              f[flip_eng - 8] = ~f[flip_eng - 8];
            end
            d_rise = r;
            d_fall = f;
        end
        @(negedge clock);
        r = 8'hFF; f = 8'hFF;
        if (!b8) begin r[7:4] = 4'($urandom); f[7:4] = 4'($urandom); end
        if (bad_end) f[0] = 1'b0;
        d_rise = r; d_fall = f;
        @(negedge clock);
        d_rise = 8'hFF; d_fall = 8'hFF;
        wait_done(dbase, 40, "blk");
        check("blk_latency", done_cyc - sb_cyc - 1, ncyc + 17);
        check("blk_busy_off", busy, 0);
        exp_crc = (flip_eng >= 0) && (b8 || (flip_eng % 8) < 4);
        check("blk_crc_err", crc_err, exp_crc);
        check("blk_end_err", end_err, bad_end);
        check("blk_timeout_err", timeout_err, 0);
        check("blk_word_count", words.size() - wbase, nb / 2);
        for (int w = 0; w < nb / 2 && wbase + w < words.size(); w++)
            check("blk_word", words[wbase + w], {blk[2 * w + 1], blk[2 * w]});
        if (!b8)
            for (int i = wbase + 1; i < vcyc.size(); i++)
                check("blk_valid_spacing", vcyc[i] - vcyc[i - 1], 2);
    endtask

    initial begin
        int wb, dbase, c0;
        int n;
        bit b8;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check("rst_outputs", {rx_valid, rx_data, busy, done, crc_err, end_err, timeout_err}, 0);
        reset = 1'b1;

        // Short length ignored; abort beats start
        @(negedge clock); start = 1'b1; bus8 = 1'b1; block_bytes = 12'd1; timeout = 24'd50;
        @(negedge clock); start = 1'b0; #1;
        check("short_len_ignored", busy, 0);
        @(negedge clock); start = 1'b1; abort = 1'b1; block_bytes = 12'd16;
        @(negedge clock); start = 1'b0; abort = 1'b0; #1;
        check("abort_beats_start", busy, 0);
        repeat (5) @(negedge clock);
        #1;
        check("idle_no_done", done_total, 0);

        // 8-bit 512-byte block, bytes i
        for (int i = 0; i < 512; i++) blk[i] = 8'(i);
        wb = words.size();
        send_block(1'b1, 512, 1000, 3, -1, 1'b0, -1, 1'b0);
        check("blk512_first", words[wb], 16'h0100);
        check("blk512_last", words[wb + 255], 16'hFFFE);

        // Same block, line-3 falling-edge CRC bit flipped
        send_block(1'b1, 512, 1000, 2, 11, 1'b0, -1, 1'b0);

        // 4-bit, A0..A7
        for (int i = 0; i < 8; i++) blk[i] = 8'hA0 + 8'(i);
        wb = words.size();
        send_block(1'b0, 8, 500, 1, -1, 1'b0, -1, 1'b0);
        check("nib_w0", words[wb], 16'hA1A0);
        check("nib_w3", words[wb + 3], 16'hA7A6);

        // Timeout with DAT idle high
        dbase = done_total;
        wb = words.size();
        @(negedge clock);
        start = 1'b1; bus8 = 1'b1; block_bytes = 12'd512; timeout = 24'd100;
        d_rise = 8'hFF; d_fall = 8'hFF; c0 = cyc;
        @(negedge clock); start = 1'b0;
        wait_done(dbase, 200, "tmo");
        check("tmo_latency", done_cyc - (c0 + 1), 100);
        check("tmo_err", timeout_err, 1);
        check("tmo_no_words", words.size() - wb, 0);
        check("tmo_other_flags", {crc_err, end_err, busy}, 0);

        // Bad end bit: line 0 low on the falling edge only
        for (int i = 0; i < 16; i++) blk[i] = 8'($urandom);
        send_block(1'b1, 16, 300, 2, -1, 1'b1, -1, 1'b0);

        // Abort at word 10, then a clean 4-bit block waiting forever (timeout 0)
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        send_block(1'b1, 512, 1000, 1, -1, 1'b0, 10, 1'b0);
        for (int i = 0; i < 20; i++) blk[i] = 8'($urandom);
        send_block(1'b0, 20, 0, 40, -1, 1'b0, -1, 1'b0);

        // Reset at word 10, then a clean 8-bit block with odd length
        for (int i = 0; i < 512; i++) blk[i] = 8'($urandom);
        send_block(1'b1, 512, 1000, 1, -1, 1'b0, 10, 1'b1);
        for (int i = 0; i < 37; i++) blk[i] = 8'($urandom);
        send_block(1'b1, 37, 800, 2, -1, 1'b0, -1, 1'b0);

        // 4-bit with a flip on an inactive line: ignored
        for (int i = 0; i < 12; i++) blk[i] = 8'($urandom);
        send_block(1'b0, 12, 400, 0, 6, 1'b0, -1, 1'b0);

        // Randomized blocks
        for (int it = 0; it < 4; it++) begin
            b8 = 1'($urandom_range(0, 1));
            n  = $urandom_range(2, 64);
            for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
            send_block(b8, n, $urandom_range(200, 1000), $urandom_range(0, 5),
                       (it == 3) ? 0 : -1, 1'b0, -1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_emmc_ddr_data_rx.md
Name: sd_emmc_ddr_data_rx

Overview:
- Receive-side counterpart of the eMMC DDR data output path.
- Takes paired rising- and falling-edge DAT samples from the input DDR capture cells and finds the start bit.
- Deserializes one data block in DDR52 mode on a 4- or 8-bit bus.
- Checks the per-line, per-edge CRC16 and the end bit, then reports status to the host-side data controller.

Parameters:
- TIMEOUT_W, 24, width of the start-bit timeout counter.
- BLEN_W, 12, width of the block length input.

Ports:
- clock  in  1  controller clock, one card-clock period per cycle.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms reception; ignored while busy.
- abort  in  1  synchronous abort; return to IDLE.
- bus8  in  1  1 = 8 data lines, 0 = 4 data lines (DAT[3:0]); sampled at start.
- block_bytes  in  BLEN_W  block length in bytes; sampled at start.
- timeout  in  TIMEOUT_W  clocks to wait for the start bit; sampled at start.
- d_rise  in  8  DAT sample from the rising edge of this cycle.
- d_fall  in  8  DAT sample from the falling edge of this cycle (same-cycle pair).
- rx_valid  out  1  rx_data holds two new bytes.
- rx_data  out  16  [7:0] = even (earlier) byte, [15:8] = odd byte.
- busy  out  1  block reception in progress.
- done  out  1  one-cycle pulse at block end; error flags are valid in the same cycle.
- crc_err  out  1  CRC mismatch on any active line or edge.
- end_err  out  1  end bit not high on all active lines.
- timeout_err  out  1  no start bit within timeout.

Behaviour:
- Reset (async, reset=0): all outputs 0, state IDLE, all CRC registers 0.
- States: IDLE -> WAIT_START -> DATA -> CRC -> END -> IDLE.
- IDLE:
  - start with block_bytes>=2 latches bus8, block_bytes, timeout.
  - Next cycle: WAIT_START, busy=1, error flags cleared.
  - start with block_bytes<2 is ignored.
  - block_bytes[0] is ignored (length is forced even).
- WAIT_START:
  - Start bit = all active lines 0 in both d_rise and d_fall of the same cycle.
  - Cycle after the start bit enters DATA.
  - Timeout counter counts cycles in WAIT_START. When it reaches timeout: timeout_err=1, done=1, IDLE.
  - timeout=0 means wait forever.
- DATA, 8-bit mode:
  - Each cycle, d_rise = even byte, d_fall = odd byte.
  - rx_valid=1 with rx_data={d_fall,d_rise} registered; output latency is 1 cycle.
  - Length: block_bytes/2 cycles.
- DATA, 4-bit mode:
  - Even bytes are carried on rising edges and odd bytes on falling edges.
  - Cycle 2k supplies the high nibbles, cycle 2k+1 the low nibbles.
  - rx_valid fires after each odd cycle.
  - Length: block_bytes cycles.
- No backpressure: the consumer must accept every rx_valid pulse.
- CRC accumulation:
  - One CRC16 per active line per edge: 16 engines in 8-bit mode, 8 in 4-bit mode.
  - Polynomial x^16+x^12+x^5+1, init 0, MSB first.
  - Updated every DATA cycle from the corresponding edge bit.
- CRC state: 16 cycles.
  - Each received bit, per line per edge, is compared with the engine MSB.
  - Then the engine shifts in 0.
  - Any mismatch sets crc_err sticky.
- END: 1 cycle.
  - End bit = all active lines 1 in d_rise and d_fall; otherwise end_err=1.
  - done=1, busy=0 next cycle, then IDLE.
- Error flags hold until the next accepted start or reset.
- All data is delivered even when crc_err is set.
- abort in any state:
  - Next cycle: IDLE, busy=0, rx_valid=0, no done pulse.
  - Flags hold their values.
  - abort has priority over start in the same cycle.
- Inactive lines (DAT[7:4] in 4-bit mode) are ignored everywhere.

Test Plan:
- 8-bit, block_bytes=512, bytes i=i[7:0], correct CRCs driven by the bench model:
  - 256 rx_valid pulses; first rx_data=16'h0100, last 16'hFFFE.
  - done arrives 256+16+1 cycles after the start-bit cycle.
  - crc_err=0, end_err=0.
- Same block with one bit flipped in the line-3 falling-edge CRC: crc_err=1, end_err=0, all 256 words still delivered.
- 4-bit, block_bytes=8, bytes 8'hA0..8'hA7: rx_valid every 2nd cycle, 4 words {A1,A0},{A3,A2},{A5,A4},{A7,A6}, crc_err=0.
- timeout=100, DAT held 8'hFF: timeout_err=1 and done exactly 100 cycles after entering WAIT_START; rx_valid never asserted.
- End bit with line 0 low on the falling edge only: end_err=1, crc_err=0, done=1.
- abort, or reset=0, at DATA word 10 of 256: busy=0 next cycle, no done pulse. A following normal block is received cleanly with flags cleared.
